// File: rtl/alu_seq.sv
// Handshaked, parametrised x86-subset ALU: push/pop/ret/call/mov/mov-imm/add/sub.
// Multi-step instructions are sequenced by a small FSM; one result word per step.
module alu_seq #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STACK_STEP = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [DATA_W-1:0] reg_sp,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_step,
  output logic              result_last,
  output logic              zf,
  output logic              cf,
  output logic              illegal
);

  localparam logic [7:0] OP_PUSH = 8'h55;
  localparam logic [7:0] OP_CALL = 8'he8;
  localparam logic [7:0] OP_POP  = 8'h5d;
  localparam logic [7:0] OP_RET  = 8'hc3;
  localparam logic [7:0] OP_MOV  = 8'h89;
  localparam logic [7:0] OP_MOVI = 8'hb8;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h29;

  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STACK_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP0 = 2'd1,
    STEP1 = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]        opcode;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W-1:0] sub_diff;
  logic [DATA_W-1:0] dec_s0, dec_s1;
  logic              dec_two, dec_ill, dec_flags, dec_cf;

  // step1 payload and step count are latched at accept so inputs may change freely
  logic [DATA_W-1:0] step1_data, step1_data_next;
  logic              two_step, two_step_next;

  logic [DATA_W-1:0] result_next;
  logic              result_valid_next, result_step_next, result_last_next;
  logic              zf_next, cf_next, illegal_next, op_ready_next;

  assign opcode = instr[31:24];

  // Instruction decode on the live operands; only consumed on the accept edge.
  always_comb begin
    dec_s0    = '0;
    dec_s1    = '0;
    dec_two   = 1'b0;
    dec_ill   = 1'b0;
    dec_flags = 1'b0;
    dec_cf    = 1'b0;
    add_sum   = {1'b0, reg_a} + {1'b0, reg_b};
    sub_diff  = reg_a - reg_b;
    case (opcode)
      OP_PUSH, OP_CALL: begin
        dec_s0  = reg_sp - STEP_W;
        dec_s1  = reg_a;
        dec_two = 1'b1;
      end
      OP_POP, OP_RET: begin
        dec_s0  = reg_sp;
        dec_s1  = reg_sp + STEP_W;
        dec_two = 1'b1;
      end
      OP_MOV:  dec_s0 = reg_a;
      OP_MOVI: dec_s0 = DATA_W'({instr[7:0], instr[15:8], instr[23:16]});
      OP_ADD: begin
        dec_s0    = add_sum[DATA_W-1:0];
        dec_cf    = add_sum[DATA_W];
        dec_flags = 1'b1;
      end
      OP_SUB: begin
        dec_s0    = sub_diff;
        dec_cf    = (reg_a < reg_b);
        dec_flags = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next        = state;
    result_next       = result;
    result_valid_next = result_valid;
    result_step_next  = result_step;
    result_last_next  = result_last;
    zf_next           = zf;
    cf_next           = cf;
    illegal_next      = illegal;
    step1_data_next   = step1_data;
    two_step_next     = two_step;
    case (state)
      IDLE: begin
        result_valid_next = 1'b0;
        if (op_valid) begin
          state_next        = STEP0;
          result_next       = dec_s0;
          result_valid_next = 1'b1;
          result_step_next  = 1'b0;
          result_last_next  = ~dec_two;
          illegal_next      = dec_ill;
          step1_data_next   = dec_s1;
          two_step_next     = dec_two;
          if (dec_flags) begin
            zf_next = (dec_s0 == '0);
            cf_next = dec_cf;
          end
        end
      end
      STEP0: begin
        if (result_ready) begin
          if (two_step) begin
            state_next       = STEP1;
            result_next      = step1_data;
            result_step_next = 1'b1;
            result_last_next = 1'b1;
            illegal_next     = 1'b0;
          end else begin
            state_next        = IDLE;
            result_valid_next = 1'b0;
          end
        end
      end
      STEP1: begin
        if (result_ready) begin
          state_next        = IDLE;
          result_valid_next = 1'b0;
        end
      end
      default: begin
        state_next        = IDLE;
        result_valid_next = 1'b0;
      end
    endcase
    op_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_step  <= 1'b0;
      result_last  <= 1'b0;
      zf           <= 1'b0;
      cf           <= 1'b0;
      illegal      <= 1'b0;
      op_ready     <= 1'b1;
      step1_data   <= '0;
      two_step     <= 1'b0;
    end else begin
      result       <= result_next;
      result_valid <= result_valid_next;
      result_step  <= result_step_next;
      result_last  <= result_last_next;
      zf           <= zf_next;
      cf           <= cf_next;
      illegal      <= illegal_next;
      op_ready     <= op_ready_next;
      step1_data   <= step1_data_next;
      two_step     <= two_step_next;
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the phase-clocked ALU. It executes the x86 subset used by the core: push, pop, ret, call, `mov r/m`, `mov eax,imm`, plus add and sub. Multi-step instructions are sequenced by an internal state machine rather than by external phase clocks. It sits between decode (instruction word plus register-file reads) and writeback/stack-memory, and delivers one result word per step over a valid/ready channel.

## Interface

- DATA_W, 32, datapath width; legal range 24..64.
- STACK_STEP, 4, bytes added or subtracted from the stack pointer per push or pop.

- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- op_valid  in  1  decode presents an instruction.
- op_ready  out  1  block can accept; high only in IDLE.
- instr  in  32  raw instruction word; opcode in [31:24], immediate bytes in [23:0].
- reg_a  in  DATA_W  source register value (ebp, return address or mov source).
- reg_b  in  DATA_W  second operand for add/sub.
- reg_sp  in  DATA_W  current esp.
- result_valid  out  1  result holds a step output.
- result_ready  in  1  consumer takes the result.
- result  out  DATA_W  step result.
- result_step  out  1  0 = first step, 1 = second step.
- result_last  out  1  this step completes the instruction.
- zf  out  1  zero flag, updated by add/sub only.
- cf  out  1  carry (add) or borrow (sub), updated by add/sub only.
- illegal  out  1  set with the result of an unknown opcode.

## Operation

- **Operand capture.** Operands `instr`, `reg_a`, `reg_b` and `reg_sp` are captured on accept (op_valid & op_ready). Later changes to these inputs have no effect on the instruction in flight.
- **States.**
  - IDLE --accept--> STEP0. The step-0 result is registered on the accept edge.
  - STEP0 --result_ready and two-step opcode--> STEP1. The step-1 result is registered on the same edge.
  - STEP0 --result_ready and one-step opcode--> IDLE.
  - STEP1 --result_ready--> IDLE.
  - Without result_ready, the state and every output hold.
- **Per-opcode results.** All sums wrap modulo 2^DATA_W.
  - 0x55 push: step0 = reg_sp - STACK_STEP (new esp); step1 = reg_a (store data).
  - 0xe8 call: step0 = reg_sp - STACK_STEP; step1 = reg_a (return address).
  - 0x5d pop and 0xc3 ret: step0 = reg_sp (read address); step1 = reg_sp + STACK_STEP (new esp).
  - 0x89 mov: step0 = reg_a; one step.
  - 0xb8 mov eax,imm: step0 = zero-extended {instr[7:0], instr[15:8], instr[23:16]}; one step.
  - 0x01 add: step0 = reg_a + reg_b. cf = carry out of bit DATA_W-1. zf = (result == 0).
  - 0x29 sub: step0 = reg_a - reg_b. cf = 1 when reg_a < reg_b (unsigned). zf = (result == 0).
  - Any other opcode: step0 = 0 and illegal = 1; one step.
- **Flags.** zf and cf change only when an add or sub result is registered; every other opcode leaves them unchanged. illegal is rewritten on every step0 (0 or 1) and cleared on step1.
- **Step outputs.** result_last = 1 on the final step of each instruction. result_step reflects the state that produced the result.

## Timing

- **Reset values.** result = 0, result_valid = 0, result_step = 0, result_last = 0, zf = 0, cf = 0, illegal = 0, state = IDLE. op_ready = 1 as soon as reset deasserts.
- **Latency.** Accept at edge N gives result_valid = 1 after edge N. With result_ready held high, step1 follows after edge N+1.
- **Throughput with result_ready = 1.**
  - One-step op: result_valid drops after the consuming edge, since IDLE has no result. The next accept can happen in that IDLE cycle, so the best rate is one op per 2 cycles.
  - Two-step op: one op per 3 cycles.
- **Hold rule.** While result_valid = 1 and result_ready = 0, result and all flags stay bit-stable.
- **No overlap.** op_ready = 0 in STEP0 and STEP1, so op_valid in those states is ignored and not queued.
- **Reset mid-operation.** Asserting reset in STEP0 or STEP1 aborts the instruction. The second step is never produced, and the flags return to 0.
- **Stack wrap.** reg_sp = 0 with push gives 2^DATA_W - STACK_STEP. No exception is raised.

## Test plan

- **Reset.** Assert reset asynchronously mid-cycle while in STEP1 of a push -> all outputs are 0 immediately, op_ready = 1 after release, and no step1 result appears.
- **Push with backpressure.** Push, reg_sp = 0x100, reg_a = 0xCAFE, result_ready low for 3 cycles -> step0 result 0xFC is held stable. Then step1 result 0xCAFE with result_last = 1, then IDLE.
- **Mov immediate.** mov imm, instr = 0xB8_12_34_56 -> result 0x00563412, one step, flags unchanged.
- **Add and sub flags.**
  - add with DATA_W = 32, 0xFFFFFFFF + 1 -> result 0, zf = 1, cf = 1.
  - A following sub 5 - 7 -> result 0xFFFFFFFE, zf = 0, cf = 1.
  - A following mov -> zf and cf unchanged.
- **Pop at wrap and operand isolation.**
  - Pop with reg_sp = 0xFFFFFFFC -> step0 0xFFFFFFFC, step1 0x00000000.
  - Changing reg_sp after accept -> no effect on either step.
- **Illegal and back-to-back.** Opcode 0x90 -> result 0, illegal = 1. Then an immediate accept in the following IDLE cycle of mov with reg_a = 7 -> result 7 with illegal = 0. Bench checks op_ready is never high outside IDLE.
